i2s_trx_core: RTL and testbench
===============================

I2S_TRX_CORE -- requirements
Module: i2s_trx_core

Interface
REQ-001 Parameter DATA_WIDTH, default 32: widest slot/word in bits; SHALL be 32.
REQ-002 Parameter DIV_WIDTH, default 8: width of the clock divider setting.
REQ-003 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 en_i  in  1  run enable; lsb_i  in  1  1 = LSB-first; fmt_i  in  1  0 = I2S Philips, 1 = left-justified.
REQ-006 chl_i  in  2  slot length 0/1/2/3 = 8/16/24/32 bits (SLOT); div_i  in  DIV_WIDTH  SCK half-period = div_i+1 clk_i cycles.
REQ-007 tx_valid_i  in  1, tx_ready_o  out  1, tx_data_i  in  DATA_WIDTH  transmit word stream.
REQ-008 rx_valid_o  out  1, rx_ready_i  in  1, rx_data_o  out  DATA_WIDTH, rx_ch_o  out  1 (0 = left, 1 = right)  receive word stream.
REQ-009 clr_i  in  1  clears sticky flags; busy_o  out  1 = en_i; tx_udr_o  out  1, rx_ovf_o  out  1  sticky error flags.
REQ-010 i2s_sck_o  out  1, i2s_ws_o  out  1, i2s_sd_o  out  1, i2s_sd_i  in  1  I2S master pins.

Function
REQ-011 Divider counts 0..div_i while en_i=1; at terminal count SCK toggles; a low->high toggle is a rise event, high->low a fall event.
REQ-012 Bit counter 0..SLOT-1 advances on each fall event; wrap toggles channel ch (left first, ch=0).
REQ-013 Slot start = first enabled cycle after en_i rises, and every fall event on which the bit counter wraps.
REQ-014 At slot start, TX shift register loads tx_data_i[SLOT-1:0] from the hold buffer, or all-zeros with tx_udr_o set if the buffer is empty.
REQ-015 i2s_sd_o shifts one bit per fall event: MSB of slot first when lsb_i=0, LSB first when lsb_i=1.
REQ-016 fmt_i=1: i2s_ws_o = ch; fmt_i=0: i2s_ws_o = channel of the next bit period (changes on the fall event of bit SLOT-1, one SCK ahead of data); MSB still aligned to slot start in both formats.
REQ-017 TX hold buffer is one word: tx_ready_o = hold empty; accepted on tx_valid_i&&tx_ready_o; emptied by load at slot start; accept and load in the same cycle are both honoured.
REQ-018 RX samples i2s_sd_i on every rise event into a shift register using the same bit order as TX.
REQ-019 On the rise event of bit SLOT-1, received word (zero-extended into bits SLOT-1:0) and its ch SHALL appear on rx_data_o/rx_ch_o with rx_valid_o=1 the next cycle.
REQ-020 rx_valid_o holds until rx_valid_o&&rx_ready_i; if a new word completes while the previous is unaccepted, the new word is dropped and rx_ovf_o set; accepted in the same cycle = no overflow.
REQ-021 tx_udr_o/rx_ovf_o clear on clr_i; a set in the same cycle as clr_i wins.
REQ-022 en_i=0: SCK, WS, SD low, divider/bit counter/ch cleared next cycle; hold buffer and rx output register retained; mid-frame deassertion aborts the frame without error flags.
REQ-023 lsb_i, fmt_i, chl_i, div_i SHALL be changed only while en_i=0; behaviour otherwise undefined.

Reset
REQ-024 rst_i=1: i2s_sck_o, i2s_ws_o, i2s_sd_o, rx_valid_o, rx_ch_o, tx_udr_o, rx_ovf_o = 0; rx_data_o = 0; hold buffer empty (tx_ready_o=1); counters and ch = 0.
REQ-025 Reset takes priority over en_i and every handshake.

Configuration
REQ-026 Macro I2S_TRX_RX_EN defined: receive path per REQ-018..020 present.
REQ-027 Macro I2S_TRX_RX_EN undefined: no RX logic; rx_valid_o, rx_ch_o, rx_ovf_o, rx_data_o tied 0; i2s_sd_i ignored; TX unchanged.

Verification
REQ-028 div_i=1, chl_i=1, fmt_i=1, en_i=1 -> SCK period 4 clk_i, WS period 128 clk_i, WS low first 64 clk_i.
REQ-029 tx 16'hA5C3 left, 16'h0FF0 right, lsb_i=0 -> SD bits A5C3 then 0FF0 MSB-first; lsb_i=1 -> bit order reversed per word.
REQ-030 fmt_i=0 -> WS toggles one SCK before MSB of 16'hA5C3; fmt_i=1 -> WS toggles with MSB.
REQ-031 Loopback sd_o->sd_i, chl_i=3, words 32'hDEADBEEF/32'h12345678, rx_ready_i=1 -> identical rx words, rx_ch_o 0 then 1, no flags.
REQ-032 No tx_valid_i for a slot -> SD all zeros, tx_udr_o=1; rx_ready_i=0 for two words -> first word kept, rx_ovf_o=1; clr_i -> both 0.
REQ-033 rst_i pulsed mid-frame -> all outputs per REQ-024 next cycle; en_i dropped mid-frame -> pins low, flags unchanged.

Source files
------------

// File: rtl/i2s_trx_core_if.sv
// i2s_trx_core_if: transmit and receive word-stream handshake bundle for i2s_trx_core
// master: drives tx_valid_i/tx_data_i/rx_ready_i, observes tx_ready_o and the rx word outputs
// slave : the core side of the same signals
interface i2s_trx_core_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  tx_valid_i;
  logic                  tx_ready_o;
  logic [DATA_WIDTH-1:0] tx_data_i;
  logic                  rx_valid_o;
  logic                  rx_ready_i;
  logic [DATA_WIDTH-1:0] rx_data_o;
  logic                  rx_ch_o;
  modport master (output tx_valid_i, tx_data_i, rx_ready_i, input tx_ready_o, rx_valid_o, rx_data_o, rx_ch_o);
  modport slave (input tx_valid_i, tx_data_i, rx_ready_i, output tx_ready_o, rx_valid_o, rx_data_o, rx_ch_o);
endinterface

// File: rtl/i2s_trx_core.sv
// i2s_trx_core: I2S master transmitter/receiver with 8/16/24/32-bit slots, MSB/LSB-first and Philips/left-justified framing
// clk_i/rst_i: clock and synchronous active-high reset
// en_i, lsb_i, fmt_i, chl_i, div_i: run enable and frame configuration (change only while en_i=0)
// clr_i, busy_o, tx_udr_o, rx_ovf_o: sticky flag clear, busy (=en_i), underrun and overflow flags
// i2s_sck_o, i2s_ws_o, i2s_sd_o, i2s_sd_i: I2S master pins
// bus: tx/rx word streams (slave modport of i2s_trx_core_if)
// Define I2S_TRX_RX_EN to build the receive path; without it the rx outputs are tied low.
module i2s_trx_core #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 lsb_i,
  input  logic                 fmt_i,
  input  logic [1:0]           chl_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 clr_i,
  output logic                 busy_o,
  output logic                 tx_udr_o,
  output logic                 rx_ovf_o,
  output logic                 i2s_sck_o,
  output logic                 i2s_ws_o,
  output logic                 i2s_sd_o,
  input  logic                 i2s_sd_i,
  i2s_trx_core_if.slave        bus
);
  logic run_q, sck_q, sck_d, ws_q, ws_d, sd_q, sd_d, ch_q, ch_d;
  logic hold_vld_q, hold_vld_d, udr_q, udr_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [4:0] bit_q, bit_d, last;
  logic [DATA_WIDTH-1:0] sr_q, sr_d, hold_q, hold_d;
  logic tc, rise, fall, wrap, start, accept;
  always_comb begin
    last = {chl_i, 3'b111};
    tc = en_i && run_q && div_q == div_i;
    rise = tc && !sck_q;
    fall = tc && sck_q;
    wrap = fall && bit_q == last;
    start = (en_i && !run_q) || wrap;
    accept = bus.tx_valid_i && !hold_vld_q;
    div_d = !en_i || div_q == div_i ? '0 : div_q + DIV_WIDTH'(1);
    sck_d = en_i && (sck_q ^ tc);
    bit_d = !en_i || wrap ? '0 : bit_q + 5'(fall);
    ch_d = en_i && (ch_q ^ wrap);
    sr_d = start ? (hold_vld_q ? hold_q : '0) : sr_q;
    // sd is picked from the held word by bit index rather than shifted, so slot length only affects indexing
    sd_d = en_i && sr_d[lsb_i ? bit_d : last - bit_d];
    // Philips framing announces the next channel during the last bit of the current slot
    ws_d = en_i && (fmt_i ? ch_d : ch_d ^ (bit_d == last));
    hold_vld_d = accept || (hold_vld_q && !start);
    hold_d = accept ? bus.tx_data_i : hold_q;
    udr_d = (start && !hold_vld_q) || (udr_q && !clr_i);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q <= 1'b0;
      div_q <= '0;
      sck_q <= 1'b0;
      ws_q <= 1'b0;
      sd_q <= 1'b0;
      ch_q <= 1'b0;
      bit_q <= '0;
      sr_q <= '0;
      hold_q <= '0;
      hold_vld_q <= 1'b0;
      udr_q <= 1'b0;
    end else begin
      run_q <= en_i;
      div_q <= div_d;
      sck_q <= sck_d;
      ws_q <= ws_d;
      sd_q <= sd_d;
      ch_q <= ch_d;
      bit_q <= bit_d;
      sr_q <= sr_d;
      hold_q <= hold_d;
      hold_vld_q <= hold_vld_d;
      udr_q <= udr_d;
    end
  end
  assign busy_o = en_i;
  assign tx_udr_o = udr_q;
  assign i2s_sck_o = sck_q;
  assign i2s_ws_o = ws_q;
  assign i2s_sd_o = sd_q;
  assign bus.tx_ready_o = !hold_vld_q;
`ifdef I2S_TRX_RX_EN
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d, rx_data_q, rx_data_d, mask;
  logic rx_vld_q, rx_vld_d, rx_ch_q, rx_ch_d, ovf_q, ovf_d, done, free;
  always_comb begin
    mask = ~({DATA_WIDTH{1'b1}} << ({1'b0, chl_i, 3'b000} + 6'd8));
    rx_sr_d = rx_sr_q;
    if (rise) rx_sr_d[lsb_i ? bit_q : last - bit_q] = i2s_sd_i;
    done = rise && bit_q == last;
    free = !rx_vld_q || bus.rx_ready_i;
    rx_vld_d = (done && free) || (rx_vld_q && !bus.rx_ready_i);
    rx_data_d = done && free ? rx_sr_d & mask : rx_data_q;
    rx_ch_d = done && free ? ch_q : rx_ch_q;
    ovf_d = (done && !free) || (ovf_q && !clr_i);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_sr_q <= '0;
      rx_data_q <= '0;
      rx_vld_q <= 1'b0;
      rx_ch_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      rx_sr_q <= rx_sr_d;
      rx_data_q <= rx_data_d;
      rx_vld_q <= rx_vld_d;
      rx_ch_q <= rx_ch_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.rx_valid_o = rx_vld_q;
  assign bus.rx_data_o = rx_data_q;
  assign bus.rx_ch_o = rx_ch_q;
  assign rx_ovf_o = ovf_q;
`else
  logic rx_unused;
  assign rx_unused = ^{i2s_sd_i, bus.rx_ready_i, rise};
  assign bus.rx_valid_o = 1'b0;
  assign bus.rx_data_o = '0;
  assign bus.rx_ch_o = 1'b0;
  assign rx_ovf_o = 1'b0;
`endif
endmodule

// File: tb/tb_i2s_trx_core.sv
// tb_i2s_trx_core: table-driven loopback bench for i2s_trx_core plus directed timing, underrun/overflow, abort and reset sequences
module tb_i2s_trx_core;
  typedef struct {
    logic        lsb;
    logic        fmt;
    logic [1:0]  chl;
    logic [7:0]  div;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [63:0] sd;
    logic [31:0] r0;
    logic [31:0] r1;
  } vec_t;
  logic clk = 0, rst, en, lsb, fmt, clr, busy, udr, ovf, sck, ws, sd;
  logic [1:0] chl;
  logic [7:0] div;
  int cyc = 0, n_chk = 0, n_pass = 0;
  logic [63:0] sd_s, ws_s;
  int got, nrx;
  logic [31:0] rx_w [2];
  logic rx_c [2];
  vec_t vt [9];
  i2s_trx_core_if #(.DATA_WIDTH(32)) bus ();
  i2s_trx_core #(.DATA_WIDTH(32), .DIV_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .lsb_i(lsb), .fmt_i(fmt), .chl_i(chl), .div_i(div),
    .clr_i(clr), .busy_o(busy), .tx_udr_o(udr), .rx_ovf_o(ovf),
    .i2s_sck_o(sck), .i2s_ws_o(ws), .i2s_sd_o(sd), .i2s_sd_i(sd), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic logic [63:0] ws_exp(input logic f, input int s);
    logic [63:0] r = '0;
    for (int k = 0; k < 2 * s; k++) r = {r[62:0], f ? (k >= s) : (k >= s - 1 && k < 2 * s - 1)};
    return r;
  endfunction
  task automatic push_idle(input logic [31:0] w);
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i = w;
    @(negedge clk);
    bus.tx_valid_i = 1'b0;
  endtask
  task automatic capture(input int nb, input logic do_push, input logic [31:0] w1);
    logic prev, pushed;
    prev = sck;
    pushed = 1'b0;
    sd_s = '0;
    ws_s = '0;
    got = 0;
    nrx = 0;
    for (int c = 0; c < 4000 && got < nb; c++) begin
      @(negedge clk);
      if (bus.tx_valid_i) bus.tx_valid_i = 1'b0;
      if (do_push && !pushed && bus.tx_ready_o) begin
        bus.tx_valid_i = 1'b1;
        bus.tx_data_i = w1;
        pushed = 1'b1;
      end
      if (!prev && sck) begin
        sd_s = {sd_s[62:0], sd};
        ws_s = {ws_s[62:0], ws};
        got++;
      end
      if (bus.rx_valid_o && bus.rx_ready_i) begin
        if (nrx < 2) begin
          rx_w[nrx] = bus.rx_data_o;
          rx_c[nrx] = bus.rx_ch_o;
        end
        nrx++;
      end
      prev = sck;
    end
    bus.tx_valid_i = 1'b0;
    chk("capture_bits", 64'(got), 64'(nb));
  endtask
  initial begin
    int e0, r1, r2, w1, w2, wf, s;
    logic ps, pw;
    vt[0] = '{1'b0, 1'b1, 2'd1, 8'd1, 32'hFFFF_A5C3, 32'h0000_0FF0, 64'hA5C3_0FF0, 32'hA5C3, 32'h0FF0};
    vt[1] = '{1'b1, 1'b1, 2'd1, 8'd1, 32'hA5C3, 32'h0FF0, 64'hC3A5_0FF0, 32'hA5C3, 32'h0FF0};
    vt[2] = '{1'b0, 1'b0, 2'd1, 8'd1, 32'hA5C3, 32'h0FF0, 64'hA5C3_0FF0, 32'hA5C3, 32'h0FF0};
    vt[3] = '{1'b1, 1'b0, 2'd1, 8'd0, 32'hA5C3, 32'h0FF0, 64'hC3A5_0FF0, 32'hA5C3, 32'h0FF0};
    vt[4] = '{1'b0, 1'b1, 2'd0, 8'd0, 32'h7777_773A, 32'hC5, 64'h3AC5, 32'h3A, 32'hC5};
    vt[5] = '{1'b1, 1'b0, 2'd0, 8'd2, 32'h3A, 32'hC5, 64'h5CA3, 32'h3A, 32'hC5};
    vt[6] = '{1'b0, 1'b0, 2'd2, 8'd0, 32'h12_3456, 32'hAB_CDEF, 64'h1234_56AB_CDEF, 32'h12_3456, 32'hAB_CDEF};
    vt[7] = '{1'b0, 1'b1, 2'd3, 8'd1, 32'hDEAD_BEEF, 32'h1234_5678, 64'hDEAD_BEEF_1234_5678, 32'hDEAD_BEEF, 32'h1234_5678};
    vt[8] = '{1'b1, 1'b1, 2'd3, 8'd0, 32'hDEAD_BEEF, 32'h1234_5678, 64'hF77D_B57B_1E6A_2C48, 32'hDEAD_BEEF, 32'h1234_5678};
    rst = 1; en = 0; lsb = 0; fmt = 1; chl = 1; div = 1; clr = 0;
    bus.tx_valid_i = 0; bus.tx_data_i = 0; bus.rx_ready_i = 1;
    repeat (3) @(negedge clk);
    chk("rst_sck", 64'(sck), 0);
    chk("rst_ws", 64'(ws), 0);
    chk("rst_sd", 64'(sd), 0);
    chk("rst_udr", 64'(udr), 0);
    chk("rst_ovf", 64'(ovf), 0);
    chk("rst_rx_valid", 64'(bus.rx_valid_o), 0);
    chk("rst_rx_ch", 64'(bus.rx_ch_o), 0);
    chk("rst_rx_data", 64'(bus.rx_data_o), 0);
    chk("rst_tx_ready", 64'(bus.tx_ready_o), 1);
    chk("rst_busy", 64'(busy), 0);
    rst = 0;
    @(negedge clk);
    r1 = -1; r2 = -1; w1 = -1; w2 = -1; wf = -1;
    en = 1; e0 = cyc; ps = sck; pw = ws;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!ps && sck) begin
        if (r1 < 0) r1 = cyc;
        else if (r2 < 0) r2 = cyc;
      end
      if (!pw && ws) begin
        if (w1 < 0) w1 = cyc;
        else if (w2 < 0) w2 = cyc;
      end
      if (pw && !ws && wf < 0) wf = cyc;
      ps = sck; pw = ws;
    end
    chk("busy_on", 64'(busy), 1);
    chk("sck_first_rise", 64'(r1 - e0), 2);
    chk("sck_period", 64'(r2 - r1), 4);
    chk("ws_low_first", 64'(w1 - e0), 64);
    chk("ws_high_len", 64'(wf - w1), 64);
    chk("ws_period", 64'(w2 - w1), 128);
    en = 0;
    @(negedge clk);
    chk("off_sck", 64'(sck), 0);
    chk("off_ws", 64'(ws), 0);
    chk("off_sd", 64'(sd), 0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      lsb = vt[i].lsb; fmt = vt[i].fmt; chl = vt[i].chl; div = vt[i].div; clr = 1;
      @(negedge clk);
      clr = 0;
      push_idle(vt[i].w0);
      en = 1;
      s = 8 * (int'(vt[i].chl) + 1);
      capture(2 * s, 1'b1, vt[i].w1);
      chk($sformatf("sd_v%0d", i), sd_s, vt[i].sd);
      chk($sformatf("ws_v%0d", i), ws_s, ws_exp(vt[i].fmt, s));
      chk($sformatf("udr_v%0d", i), 64'(udr), 0);
`ifdef I2S_TRX_RX_EN
      chk($sformatf("rx_n_v%0d", i), 64'(nrx), 2);
      chk($sformatf("rx_w0_v%0d", i), 64'(rx_w[0]), 64'(vt[i].r0));
      chk($sformatf("rx_c0_v%0d", i), 64'(rx_c[0]), 0);
      chk($sformatf("rx_w1_v%0d", i), 64'(rx_w[1]), 64'(vt[i].r1));
      chk($sformatf("rx_c1_v%0d", i), 64'(rx_c[1]), 1);
`else
      chk($sformatf("rx_n_v%0d", i), 64'(nrx), 0);
`endif
      chk($sformatf("ovf_v%0d", i), 64'(ovf), 0);
      en = 0;
    end
    @(negedge clk);
    clr = 1; chl = 0; div = 0; fmt = 1; lsb = 0; bus.rx_ready_i = 0;
    @(negedge clk);
    clr = 0;
    push_idle(32'hA5);
    en = 1;
    capture(16, 1'b0, 32'h0);
    chk("udr_sd", sd_s, 64'hA500);
    chk("udr_set", 64'(udr), 1);
`ifdef I2S_TRX_RX_EN
    chk("ovf_rx_valid", 64'(bus.rx_valid_o), 1);
    chk("ovf_rx_data", 64'(bus.rx_data_o), 64'hA5);
    chk("ovf_rx_ch", 64'(bus.rx_ch_o), 0);
    chk("ovf_set", 64'(ovf), 1);
`else
    chk("norx_valid", 64'(bus.rx_valid_o), 0);
    chk("norx_ovf", 64'(ovf), 0);
`endif
    en = 0;
    @(negedge clk);
    chl = 3; div = 1;
    @(negedge clk);
    push_idle(32'hFFFF_FFFF);
    en = 1;
    repeat (12) @(negedge clk);
    chk("abort_sd_before", 64'(sd), 1);
    en = 0;
    @(negedge clk);
    chk("abort_sck", 64'(sck), 0);
    chk("abort_ws", 64'(ws), 0);
    chk("abort_sd", 64'(sd), 0);
    repeat (3) @(negedge clk);
    chk("abort_udr_kept", 64'(udr), 1);
`ifdef I2S_TRX_RX_EN
    chk("abort_ovf_kept", 64'(ovf), 1);
    chk("abort_rx_kept", 64'(bus.rx_data_o), 64'hA5);
`endif
    clr = 1;
    @(negedge clk);
    clr = 0;
    chk("clr_udr", 64'(udr), 0);
    chk("clr_ovf", 64'(ovf), 0);
    bus.rx_ready_i = 1;
    @(negedge clk);
    chk("rx_drained", 64'(bus.rx_valid_o), 0);
    chl = 1; div = 1; fmt = 0;
    @(negedge clk);
    push_idle(32'h1234);
    en = 1;
    repeat (3) @(negedge clk);
    push_idle(32'h5678);
    chk("hold_full", 64'(bus.tx_ready_o), 0);
    repeat (20) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mrst_sck", 64'(sck), 0);
    chk("mrst_ws", 64'(ws), 0);
    chk("mrst_sd", 64'(sd), 0);
    chk("mrst_tx_ready", 64'(bus.tx_ready_o), 1);
    chk("mrst_rx_valid", 64'(bus.rx_valid_o), 0);
    chk("mrst_rx_data", 64'(bus.rx_data_o), 0);
    chk("mrst_udr", 64'(udr), 0);
    chk("mrst_ovf", 64'(ovf), 0);
    rst = 0; en = 0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
